bht_port_scheduler: RTL
=======================

Name: bht_port_scheduler

Overview:
- Owns the single read/write port of the 2-bit-counter branch history table (BHT) behind the branch predictor.
- Arbitrates between two users: fetch-stage prediction lookups, and resolved-branch counter updates.
- Updates are buffered in a small FIFO and applied as read-modify-write sequences.
- After reset or on request, sweeps the table to a known initial state.

Parameters:
- IDX_W, 6, BHT index width (table holds 2^IDX_W entries).
- QDEPTH, 4, update FIFO depth in entries (power of 2, at least 2).
- STARVE_MAX, 4, consecutive fetch grants tolerated while updates wait.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init_req  in  1  pulse; restart the table sweep.
- fetch_req  in  1  fetch lookup request this cycle.
- fetch_idx  in  IDX_W  lookup index (low PC bits).
- fetch_gnt  out  1  lookup issued to the BHT this cycle.
- pred_vld  out  1  prediction valid (one cycle after fetch_gnt).
- pred_taken  out  1  predicted direction; equals bht_rdata[1] when pred_vld=1.
- upd_vld  in  1  resolved-branch update offered.
- upd_idx  in  IDX_W  index of the resolved branch.
- upd_taken  in  1  actual outcome of the resolved branch.
- upd_ready  out  1  FIFO can accept; an update is enqueued when upd_vld and upd_ready are both 1.
- init_done  out  1  high once the sweep completes.
- bht_en  out  1  BHT port enable.
- bht_we  out  1  BHT write enable.
- bht_addr  out  IDX_W  BHT address.
- bht_wdata  out  2  BHT write data.
- bht_rdata  in  2  BHT read data; synchronous, valid the cycle after a read.

Behaviour:
- Reset values (rst_n=0, asynchronous):
  - state=INIT, sweep address=0, FIFO count=0, starve_cnt=0.
  - pred_vld=0, init_done=0.
  - Combinational outputs bht_en, bht_we and fetch_gnt are therefore 0 except as driven by INIT.
- upd_ready = (count != QDEPTH). This depends on count only, never on the same-cycle pop.
- Enqueue and pop in the same cycle leave count unchanged. Wrap-around of the read/write pointers is modulo QDEPTH.
- The FIFO accepts updates in every state, including INIT.
- FSM states: INIT, RUN, WB.
- INIT:
  - Each cycle: bht_en=1, bht_we=1, bht_addr=sweep address, bht_wdata=2'b10 (weakly taken); then increment the address.
  - After writing entry 2^IDX_W-1: go to RUN and set init_done=1, so the sweep takes exactly 2^IDX_W cycles.
  - fetch_gnt=0 throughout INIT.
- RUN, arbitration:
  - upd_wins = (count != 0) and (!fetch_req or count == QDEPTH or starve_cnt == STARVE_MAX).
  - If upd_wins: bht_en=1, bht_we=0, bht_addr=head idx. Pop the head, latch its idx and taken into the WB registers, clear starve_cnt, go to WB.
  - Else if fetch_req: fetch_gnt=1, bht_en=1, bht_we=0, bht_addr=fetch_idx.
    - If count != 0, starve_cnt increments, saturating at STARVE_MAX.
    - If count == 0, starve_cnt clears.
  - Otherwise the port is idle.
- WB:
  - bht_en=1, bht_we=1, bht_addr=latched idx, fetch_gnt=0.
  - bht_wdata is the saturating update of bht_rdata:
    - taken: 3 stays 3, otherwise +1;
    - not taken: 0 stays 0, otherwise -1.
  - Next state is always RUN. Each update therefore costs 2 port cycles.
- pred_vld is a register of fetch_gnt. pred_taken = bht_rdata[1], qualified by pred_vld.
- Hazard: a lookup to an index whose update is still queued returns the stale counter. This is accepted behaviour and is not forwarded.
- init_req=1 in any state:
  - Next state is INIT with sweep address 0 and init_done=0.
  - The FIFO is flushed (count=0, pointers 0) and starve_cnt=0.
  - A WB in progress that cycle is still performed; the next one is abandoned.
  - An upd_vld arriving in the same cycle as init_req is dropped.
- init_req held during INIT keeps restarting the sweep at address 0.

Test Plan:
1. Reset release -> 64 consecutive write cycles to addr 0..63 with wdata=2'b10; init_done rises in the cycle after the addr-63 write; fetch_gnt=0 throughout.
2. After init, fetch_req with fetch_idx=5 and no updates -> fetch_gnt=1 and bht_addr=5 the same cycle; next cycle pred_vld=1 and pred_taken=1.
3. Three updates to idx 9: taken, taken, taken, with fetch idle. Expected:
   - RD/WR pairs write 2'b11, 2'b11, 2'b11 (2→3, then saturate);
   - then a not-taken update writes 2'b10.
4. fetch_req held high continuously, one queued update -> 4 fetch grants, then 1 update read, 1 WB cycle with fetch_gnt=0, then fetch grants resume.
5. Fill the FIFO with 4 updates while fetch_req is high -> upd_ready=0; the update wins the next RUN cycle; upd_ready returns to 1 the cycle after the pop.
6. init_req asserted during WB with 2 updates queued -> the WB write occurs, count goes to 0, the sweep restarts at addr 0, and init_done=0 until the sweep completes.

Source files
------------

// File: rtl/bht_port_scheduler.sv
// bht_port_scheduler
//
// Owns the single read/write port of the 2-bit-counter branch history table.
// Fetch-stage lookups and resolved-branch counter updates share the port.
// Updates are buffered in a small FIFO and applied as a read cycle followed
// by a write-back cycle. After reset, or on init_req, every entry is swept to
// weakly-taken (2'b10) before normal operation starts.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   init_req                   restart the table sweep (flushes queued updates)
//   fetch_req/fetch_idx        lookup request and index
//   fetch_gnt                  lookup issued to the BHT this cycle
//   pred_vld/pred_taken        prediction, one cycle after fetch_gnt
//   upd_vld/upd_idx/upd_taken  resolved-branch update offer
//   upd_ready                  update FIFO not full
//   init_done                  sweep complete
//   bht_en/we/addr/wdata       BHT port controls
//   bht_rdata                  BHT read data, valid the cycle after a read
module bht_port_scheduler #(
    parameter int IDX_W      = 6,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_req,
    input  logic             fetch_req,
    input  logic [IDX_W-1:0] fetch_idx,
    output logic             fetch_gnt,
    output logic             pred_vld,
    output logic             pred_taken,
    input  logic             upd_vld,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             init_done,
    output logic             bht_en,
    output logic             bht_we,
    output logic [IDX_W-1:0] bht_addr,
    output logic [1:0]       bht_wdata,
    input  logic [1:0]       bht_rdata
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] FULL       = CNT_W'(QDEPTH);
    localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [IDX_W-1:0] LAST_IDX   = '1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_WB
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  sweep_addr;

    logic [IDX_W-1:0]  q_idx   [QDEPTH];
    logic              q_taken [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [SC_W-1:0]   starve_cnt;

    logic [IDX_W-1:0]  wb_idx;
    logic              wb_taken;

    logic              push;
    logic              pop;
    logic              upd_wins;
    logic [1:0]        sat_wdata;

    assign upd_ready  = (count != FULL);
    // init_req drops any update offered in the same cycle.
    assign push       = upd_vld && upd_ready && !init_req;
    // Updates win when fetch is idle, the FIFO is full, or fetch has starved them long enough.
    assign upd_wins   = (count != '0) &&
                        (!fetch_req || (count == FULL) || (starve_cnt == STARVE_LIM));
    assign pred_taken = pred_vld & bht_rdata[1];

    // Saturating 2-bit counter step applied to the value read in the previous cycle.
    always_comb begin
        sat_wdata = bht_rdata;
        if (wb_taken) begin
            if (bht_rdata != 2'b11) begin
                sat_wdata = bht_rdata + 2'b01;
            end
        end else begin
            if (bht_rdata != 2'b00) begin
                sat_wdata = bht_rdata - 2'b01;
            end
        end
    end

    // Next-state and port control; init_req overrides the next state from any state.
    always_comb begin
        next_state = state;
        bht_en     = 1'b0;
        bht_we     = 1'b0;
        bht_addr   = '0;
        bht_wdata  = 2'b00;
        fetch_gnt  = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_INIT: begin
                bht_en    = 1'b1;
                bht_we    = 1'b1;
                bht_addr  = sweep_addr;
                bht_wdata = 2'b10;
                if (sweep_addr == LAST_IDX) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (upd_wins) begin
                    bht_en     = 1'b1;
                    bht_addr   = q_idx[rd_ptr];
                    pop        = 1'b1;
                    next_state = ST_WB;
                end else if (fetch_req) begin
                    fetch_gnt = 1'b1;
                    bht_en    = 1'b1;
                    bht_addr  = fetch_idx;
                end
            end
            ST_WB: begin
                bht_en     = 1'b1;
                bht_we     = 1'b1;
                bht_addr   = wb_idx;
                bht_wdata  = sat_wdata;
                next_state = ST_RUN;
            end
            default: next_state = ST_INIT;
        endcase
        if (init_req) begin
            next_state = ST_INIT;
        end
    end

    // State register, sweep address and init_done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            sweep_addr <= '0;
            init_done  <= 1'b0;
        end else begin
            state <= next_state;
            if (init_req) begin
                sweep_addr <= '0;
                init_done  <= 1'b0;
            end else if (state == ST_INIT) begin
                sweep_addr <= sweep_addr + 1'b1;
                if (sweep_addr == LAST_IDX) begin
                    init_done <= 1'b1;
                end
            end
        end
    end

    // FIFO storage has no reset; occupancy is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr]   <= upd_idx;
            q_taken[wr_ptr] <= upd_taken;
        end
    end

    // FIFO pointers and occupancy; init_req flushes everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (init_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Starvation counter: fetch grants while updates wait, cleared when an update is served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (init_req || pop) begin
            starve_cnt <= '0;
        end else if (fetch_gnt) begin
            if (count == '0) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Write-back registers for the update being applied, and the prediction valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_idx   <= '0;
            wb_taken <= 1'b0;
            pred_vld <= 1'b0;
        end else begin
            pred_vld <= fetch_gnt;
            if (pop) begin
                wb_idx   <= q_idx[rd_ptr];
                wb_taken <= q_taken[rd_ptr];
            end
        end
    end

endmodule
